// File: rtl/sync_fifo_ft_if.sv
// Handshake and status bundle for sync_fifo_ft.
// The master side is the producer/consumer; the slave side is the FIFO.
interface sync_fifo_ft_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          flush;
  logic          clr_err;
  logic          wen;
  logic [DW-1:0] data_in;
  logic          ren;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output flush, clr_err, wen, data_in, ren,
    input  data_out, data_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wen, data_in, ren,
    output data_out, data_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ft.sv
// Single-clock FIFO with extra-MSB pointers, occupancy count, almost flags,
// standard or first-word-fall-through read mode, flush and sticky error flags.
module sync_fifo_ft #(
  parameter int DW        = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_ft_if.slave  bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] AF_C = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0] AE_C = (AW + 1)'(AE_THRESH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dvalid_q, dvalid_d;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          wr_acc;
  logic          rd_acc;

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_comb begin
    wr_acc   = bus.wen && !full && !bus.flush;
    rd_acc   = bus.ren && !empty && !bus.flush;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;

    // Setting an error wins over clearing it in the same cycle.
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (!bus.flush) begin
      if (bus.wen && full)  ovf_d = 1'b1;
      if (bus.ren && empty) unf_d = 1'b1;
    end

    if (bus.flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) begin
        rptr_d   = rptr_q + 1'b1;
        dout_d   = mem_q[rptr_q[AW-1:0]];
        dvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[AW-1:0]] <= bus.data_in;
  end

  assign bus.data_out     = (FWFT != 0) ? (empty ? '0 : mem_q[rptr_q[AW-1:0]]) : dout_q;
  assign bus.data_valid   = (FWFT != 0) ? !empty : dvalid_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.count        = count;
  assign bus.almost_empty = (count <= AE_C);
  assign bus.almost_full  = (count >= AF_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
